// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared types and step tables for the six-step commutation controller.
// Contents: FSM state enum, first/last step constants, per-step high/low phase masks.
// Phase masks are one-hot {C,B,A}; the floating phase is the bit set in neither mask.
package motoro3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [2:0] STEP_FIRST = 3'd0;
  localparam logic [2:0] STEP_LAST  = 3'd5;

  localparam logic [2:0] PH_A = 3'b001;
  localparam logic [2:0] PH_B = 3'b010;
  localparam logic [2:0] PH_C = 3'b100;

  // Phase switched to the high side in each step.
  function automatic logic [2:0] step_hi(input logic [2:0] step);
    case (step)
      3'd0, 3'd1: step_hi = PH_A;
      3'd2, 3'd3: step_hi = PH_B;
      3'd4, 3'd5: step_hi = PH_C;
      default:    step_hi = 3'b000;
    endcase
  endfunction

  // Phase switched to the low side in each step.
  function automatic logic [2:0] step_lo(input logic [2:0] step);
    case (step)
      3'd0:       step_lo = PH_B;
      3'd1, 3'd2: step_lo = PH_C;
      3'd3, 3'd4: step_lo = PH_A;
      3'd5:       step_lo = PH_B;
      default:    step_lo = 3'b000;
    endcase
  endfunction

  // Next step in the commutation ring; dir = 1 walks backwards.
  function automatic logic [2:0] step_next(input logic [2:0] step, input logic dir);
    if (dir) begin
      step_next = (step == STEP_FIRST) ? STEP_LAST : step - 3'd1;
    end else begin
      step_next = (step >= STEP_LAST) ? STEP_FIRST : step + 3'd1;
    end
  endfunction

endpackage

// File: rtl/motoro3_step_decode.sv
// motoro3_step_decode: maps the current step, PWM level and blanking onto the six gate lines.
// Latency: purely combinational, same cycle as the registered step it decodes.
// Backpressure: none; outputs are level decodes with no handshake.
// Ports: step (0-5), pwm, active (controller running), blank (dead-time window)
//        -> aE/bE/cE enables and aH1_L0/bH1_L0/cH1_L0 side selects.
module motoro3_step_decode (
  input  logic [2:0] step,
  input  logic       pwm,
  input  logic       active,
  input  logic       blank,
  output logic       aE,
  output logic       bE,
  output logic       cE,
  output logic       aH1_L0,
  output logic       bH1_L0,
  output logic       cH1_L0
);
  import motoro3_pkg::*;

  logic [2:0] hi_mask;
  logic [2:0] lo_mask;
  logic [2:0] en_vec;
  logic [2:0] side_vec;

  always_comb begin
    hi_mask  = step_hi(step);
    lo_mask  = step_lo(step);
    en_vec   = 3'b000;
    side_vec = 3'b000;
    if (active) begin
      // Side select stays valid through blanking so the driver sees a stable polarity.
      side_vec = hi_mask;
      if (!blank) begin
        en_vec = (hi_mask & {3{pwm}}) | lo_mask;
      end
    end
  end

  assign {cE, bE, aE}             = en_vec;
  assign {cH1_L0, bH1_L0, aH1_L0} = side_vec;

endmodule

// File: rtl/motoro3_commutation_ctrl.sv
// motoro3_commutation_ctrl: six-step 3-phase commutation with start ramp, PWM and optional dead-time.
// Latency: step/count/state registered; gate lines decode registered state in the same cycle.
// Backpressure: none; host inputs are levels sampled every cycle (m3dir only at step boundaries).
// Ports: clk, nRst (async active-low); host m3start/m3dir/m3period/m3duty;
//        gate pwm, aE/bE/cE, aH1_L0/bH1_L0/cH1_L0; status m3step, m3cnt, m3running, m3locked.
// Build option: define MOTORO3_DEADTIME_EN to blank all enables for DEAD_CYC cycles per step.
module motoro3_commutation_ctrl #(
  parameter int CNT_W        = 25,
  parameter int PWM_W        = 8,
  parameter int START_PERIOD = 100000,
  parameter int RAMP_DEC     = 1000,
  parameter int DEAD_CYC     = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3start,
  input  logic             m3dir,
  input  logic [CNT_W-1:0] m3period,
  input  logic [PWM_W-1:0] m3duty,
  output logic             pwm,
  output logic             aE,
  output logic             bE,
  output logic             cE,
  output logic             aH1_L0,
  output logic             bH1_L0,
  output logic             cH1_L0,
  output logic [2:0]       m3step,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3running,
  output logic             m3locked
);
  import motoro3_pkg::*;

  localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] RAMP_D  = CNT_W'(RAMP_DEC);
  localparam logic [CNT_W-1:0] DEAD_C  = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(2);

`ifdef MOTORO3_DEADTIME_EN
  localparam bit DEADTIME_ON = 1'b1;
`else
  localparam bit DEADTIME_ON = 1'b0;
`endif

  state_t           state_q, state_d;
  state_t           resume_q;
  logic [2:0]       step_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [PWM_W-1:0] pwmcnt_q;

  logic             running;
  logic             locked;
  logic             last1;
  logic             reload_ramp;
  logic             ramp_done;
  logic [CNT_W-1:0] ramp_sub;
  logic [CNT_W-1:0] ramp_next;
  logic [CNT_W-1:0] start_raw;
  logic             pwm_lvl;
  logic             blank;

  // Periods below two cycles would make last1 ambiguous, so every loaded period is floored at 2.
  function automatic logic [CNT_W-1:0] clamp2(input logic [CNT_W-1:0] p);
    clamp2 = (p < MIN_P) ? MIN_P : p;
  endfunction

  assign last1     = (cnt_q == period_q - CNT_W'(1));
  assign start_raw = (START_P > m3period) ? START_P : m3period;
  assign ramp_sub  = (period_q > RAMP_D) ? (period_q - RAMP_D) : '0;
  assign ramp_next = (ramp_sub > m3period) ? ramp_sub : m3period;
  // Ramp ends once the target wins the max(), including a target raised above the ramp.
  assign ramp_done = (ramp_next == m3period);

  // A STOP that resumes at the boundary reloads as the state it interrupted.
  assign reload_ramp = (state_q == ST_RAMP) || ((state_q == ST_STOP) && (resume_q == ST_RAMP));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_RAMP;
    end else begin
      state_q <= state_d;
      if (((state_q == ST_RAMP) || (state_q == ST_RUN)) && (state_d == ST_STOP)) begin
        resume_q <= state_q;
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m3start) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        // A drop on the boundary cycle means the step is already complete: go straight to IDLE.
        if (!m3start)                state_d = last1 ? ST_IDLE : ST_STOP;
        else if (last1 && ramp_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!m3start) state_d = last1 ? ST_IDLE : ST_STOP;
      end
      ST_STOP: begin
        if (last1) begin
          if (!m3start)                           state_d = ST_IDLE;
          else if (reload_ramp && !ramp_done)     state_d = ST_RAMP;
          else                                    state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    running = (state_q != ST_IDLE);
    locked  = (state_q == ST_RUN);
  end

  // ---------------- step / count / period / PWM datapath ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      step_q   <= STEP_FIRST;
      cnt_q    <= '0;
      period_q <= MIN_P;
      pwmcnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q    <= '0;
      pwmcnt_q <= '0;
      if (m3start) begin
        step_q   <= m3dir ? STEP_LAST : STEP_FIRST;
        period_q <= clamp2(start_raw);
      end else begin
        step_q <= STEP_FIRST;
      end
    end else if (state_d == ST_IDLE) begin
      cnt_q    <= '0;
      step_q   <= STEP_FIRST;
      pwmcnt_q <= '0;
    end else begin
      pwmcnt_q <= pwmcnt_q + PWM_W'(1);
      if (last1) begin
        cnt_q    <= '0;
        step_q   <= step_next(step_q, m3dir);
        period_q <= reload_ramp ? clamp2(ramp_next) : clamp2(m3period);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pwm_lvl = running && (pwmcnt_q < m3duty);
  assign blank   = DEADTIME_ON && running && (cnt_q < DEAD_C);

  motoro3_step_decode u_decode (
    .step   (step_q),
    .pwm    (pwm_lvl),
    .active (running),
    .blank  (blank),
    .aE     (aE),
    .bE     (bE),
    .cE     (cE),
    .aH1_L0 (aH1_L0),
    .bH1_L0 (bH1_L0),
    .cH1_L0 (cH1_L0)
  );

  assign pwm       = pwm_lvl;
  assign m3step    = step_q;
  assign m3cnt     = cnt_q;
  assign m3running = running;
  assign m3locked  = locked;

endmodule

// File: tb/tb_motoro3_commutation_ctrl.sv
`timescale 1ns/1ps
// tb_motoro3_commutation_ctrl: directed scenarios plus random host traffic against a behavioural model.
module tb_motoro3_commutation_ctrl;

  localparam int CNT_W = 16;
  localparam int PWM_W = 8;
  localparam int START = 100;
  localparam int RDEC  = 10;
  localparam int DEADC = 4;
`ifdef MOTORO3_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nRst = 1'b0;
  logic             m3start = 1'b0;
  logic             m3dir = 1'b0;
  logic [CNT_W-1:0] m3period = '0;
  logic [PWM_W-1:0] m3duty = '0;
  logic             pwm, aE, bE, cE, aH1_L0, bH1_L0, cH1_L0;
  logic [2:0]       m3step;
  logic [CNT_W-1:0] m3cnt;
  logic             m3running, m3locked;

  int errors = 0;
  int checks = 0;

  always #50 clk = ~clk;

  motoro3_commutation_ctrl #(
    .CNT_W(CNT_W), .PWM_W(PWM_W), .START_PERIOD(START), .RAMP_DEC(RDEC), .DEAD_CYC(DEADC)
  ) dut (
    .clk(clk), .nRst(nRst), .m3start(m3start), .m3dir(m3dir), .m3period(m3period),
    .m3duty(m3duty), .pwm(pwm), .aE(aE), .bE(bE), .cE(cE), .aH1_L0(aH1_L0),
    .bH1_L0(bH1_L0), .cH1_L0(cH1_L0), .m3step(m3step), .m3cnt(m3cnt),
    .m3running(m3running), .m3locked(m3locked)
  );

  // Behavioural model: motor on/off, ramp-vs-locked, stop-pending flags and step timing in ints.
  int m_on, m_lock, m_stop, m_step, m_cnt, m_per, m_pwm;
  int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
  int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int eff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_on = 0; m_lock = 0; m_stop = 0; m_step = 0; m_cnt = 0; m_per = 2; m_pwm = 0;
  endtask

  task automatic model_edge();
    int bnd, np, tgt;
    tgt = int'(m3period);
    if (m_on == 0) begin
      if (m3start) begin
        m_on = 1; m_lock = 0; m_stop = 0; m_cnt = 0; m_pwm = 0;
        m_step = m3dir ? 5 : 0;
        m_per = eff(maxi(START, tgt));
      end
    end else begin
      bnd = (m_cnt == m_per - 1) ? 1 : 0;
      m_pwm = (m_pwm + 1) % 256;
      if (bnd == 1 && !m3start) begin
        model_reset();
      end else if (bnd == 1) begin
        m_stop = 0; m_cnt = 0;
        m_step = m3dir ? (m_step + 5) % 6 : (m_step + 1) % 6;
        if (m_lock == 1) m_per = eff(tgt);
        else begin
          np = maxi(maxi(m_per - RDEC, 0), tgt);
          if (np == tgt) m_lock = 1;
          m_per = eff(np);
        end
      end else begin
        m_cnt++;
        if (!m3start) m_stop = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [2:0] hi, lo, ee;
    logic pw, bl;
    pw = (m_on == 1) && (m_pwm < int'(m3duty));
    bl = DT && (m_on == 1) && (m_cnt < DEADC);
    hi = (m_on == 1) ? (3'b001 << hi_ph[m_step]) : 3'b000;
    lo = (m_on == 1) ? (3'b001 << lo_ph[m_step]) : 3'b000;
    ee = bl ? 3'b000 : ((hi & {3{pw}}) | lo);
    chk("running", m3running, (m_on == 1));
    chk("locked", m3locked, (m_on == 1) && (m_lock == 1) && (m_stop == 0));
    chk("step", m3step, m_step);
    chk("cnt", m3cnt, m_cnt);
    chk("pwm", pwm, pw);
    chk("enables", {cE, bE, aE}, ee);
    chk("sides", {cH1_L0, bH1_L0, aH1_L0}, hi);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_change(output int n);
    logic [2:0] s;
    s = m3step;
    n = 0;
    do begin
      tick();
      n++;
    end while (m3step == s && m3running && n < 1000);
    chk("step_change_timeout", (n < 1000), 1);
  endtask

  int lens[6]   = '{100, 90, 80, 70, 60, 60};
  int seqf[6]   = '{1, 2, 3, 4, 5, 0};
  int lockf[6]  = '{0, 0, 0, 1, 1, 1};

  initial begin
    int n, hcount;
    model_reset();

    // Reset state.
    #30;
    chk("rst_running", m3running, 0);
    chk("rst_step", m3step, 0);
    chk("rst_cnt", m3cnt, 0);
    chk("rst_gates", {pwm, cE, bE, aE, cH1_L0, bH1_L0, aH1_L0, m3locked}, 0);
    #100 nRst = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Forward ramp 100,90,80,70 then locked at 60.
    m3period = 16'd60; m3duty = 8'd100; m3dir = 1'b0; m3start = 1'b1;
    tick();
    chk("fwd_first_step", m3step, 0);
    chk("fwd_running", m3running, 1);
    for (int k = 0; k < 6; k++) begin
      wait_change(n);
      chk("fwd_len", n, lens[k]);
      chk("fwd_seq", m3step, seqf[k]);
      chk("fwd_lock", m3locked, lockf[k]);
    end

    // Drop start at m3cnt=10 of a 60-cycle step: 50 more cycles then IDLE.
    n = 0;
    while (m3cnt != 16'd10 && n < 200) begin tick(); n++; end
    chk("cnt10_timeout", (n < 200), 1);
    m3start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (m3running && n < 200);
    chk("stop_len", n, 50);
    chk("stop_gates", {cE, bE, aE}, 0);

    // Reverse from IDLE, then flip direction partway through step 2.
    m3dir = 1'b1; m3start = 1'b1;
    tick();
    chk("rev_first_step", m3step, 5);
    for (int k = 0; k < 3; k++) begin
      wait_change(n);
      chk("rev_seq", m3step, 4 - k);
    end
    for (int i = 0; i < 20; i++) tick();
    m3dir = 1'b0;
    wait_change(n);
    chk("dir_flip_step", m3step, 3);

    // Asynchronous reset in the middle of a run.
    #20 nRst = 1'b0;
    #2;
    chk("arst_running", m3running, 0);
    chk("arst_step", m3step, 0);
    chk("arst_gates", {pwm, cE, bE, aE, cH1_L0, bH1_L0, aH1_L0, m3locked}, 0);
    model_reset();
    m3start = 1'b0;
    #5 nRst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_idle", m3running, 0);

    // PWM at duty 64 inside one long step 0.
    m3period = 16'd400; m3duty = 8'd64; m3dir = 1'b0; m3start = 1'b1;
    tick();
    hcount = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm) hcount++;
      if (i == 10) begin
        chk("s0_aE", aE, 1);
        chk("s0_bE", bE, 1);
        chk("s0_cE", cE, 0);
        chk("s0_aH", aH1_L0, 1);
      end
      tick();
    end
    chk("pwm_high_count", hcount, 64);

    // Random host traffic against the model.
    m3period = 16'd30;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) m3start = ~m3start;
      if ($urandom_range(0, 99) == 0) m3dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) m3period = 16'($urandom_range(0, 70));
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0: m3duty = 8'd0;
          1: m3duty = 8'd255;
          default: m3duty = 8'($urandom_range(0, 255));
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
